// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry instruction
// buffer toward decode, with redirect taking priority over every handshake.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [31:0] inst_buf;
   logic        buf_ld;
   logic [31:0] redir_pc;

   assign redir_pc  = redirect_pc & ~32'h3;
   assign imem_addr = pc;
   assign inst      = inst_buf;
   assign inst_pc   = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         inst_buf <= 32'h0000_0013;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (buf_ld) inst_buf <= imem_resp_data;
      end
   end

   // Redirect masks both valids so no handshake can complete in a redirect cycle.
   always_comb begin
      state_nx       = state;
      pc_nx          = pc;
      buf_ld         = 1'b0;
      imem_req_valid = !rst && (state == S_REQ)  && !redirect_valid;
      inst_valid     = !rst && (state == S_HOLD) && !redirect_valid;
      case (state)
         S_REQ: begin
            if (redirect_valid)      pc_nx    = redir_pc;
            else if (imem_req_ready) state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_nx    = redir_pc;
               state_nx = imem_resp_valid ? S_REQ : S_DROP;
            end else if (imem_resp_valid) begin
               buf_ld   = 1'b1;
               state_nx = S_HOLD;
            end
         end
         S_DROP: begin
            // The response still owed by memory belongs to the old path.
            if (redirect_valid)  pc_nx    = redir_pc;
            if (imem_resp_valid) state_nx = S_REQ;
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_nx    = redir_pc;
               state_nx = S_REQ;
            end else if (inst_ready) begin
               pc_nx    = pc + 32'd4;
               state_nx = S_REQ;
            end
         end
         default: state_nx = S_REQ;
      endcase
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a memory model plus a program-order scoreboard (expected pc,
// data = f(address)), directed scenarios followed by randomized traffic.
module tb_ifu_fetch;
   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          checks = 0;
   int          errors = 0;

   // memory model / scoreboard state
   logic [31:0] exp_pc = RPC;
   logic        pend = 1'b0;
   int          cnt = 0;
   int          lat = 1;
   logic [31:0] paddr = 32'h0;
   int          delivered = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_inst = 32'h0, prev_ipc = 32'h0;

   ifu_fetch #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == RPC) return 32'h0010_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs at negedge, check settled outputs, advance the model.
   task automatic step(input logic r, input logic rdy, input logic ir,
                       input logic rv, input logic [31:0] rp);
      @(negedge clk);
      rst = r; imem_req_ready = rdy; inst_ready = ir;
      redirect_valid = rv; redirect_pc = rp;
      if (pend) cnt--;
      imem_resp_valid = pend && (cnt == 0);
      imem_resp_data  = imem_resp_valid ? memf(paddr) : $urandom;
      #1;
      if (r) begin
         chk("rst_reqv", imem_req_valid, 0);
         chk("rst_iv", inst_valid, 0);
      end else begin
         chk("addr", imem_addr, exp_pc);
         chk("excl", imem_req_valid & inst_valid, 0);
         if (rv) begin
            chk("redir_reqv", imem_req_valid, 0);
            chk("redir_iv", inst_valid, 0);
         end
         if (inst_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst, memf(exp_pc));
         end
         if (prev_stall && !rv) begin
            chk("stall_iv", inst_valid, 1);
            chk("stall_inst", inst, prev_inst);
            chk("stall_pc", inst_pc, prev_ipc);
         end
      end
      if (imem_resp_valid) pend = 1'b0;
      if (!r && imem_req_valid && imem_req_ready) begin
         chk("one_out", pend, 0);
         pend = 1'b1; cnt = lat; paddr = imem_addr;
      end
      if (r)                            exp_pc = RPC;
      else if (rv)                      exp_pc = rp & ~32'h3;
      else if (inst_valid && inst_ready) begin
         exp_pc = exp_pc + 32'd4;
         delivered++;
      end
      prev_stall = !r && inst_valid && !inst_ready;
      prev_inst  = inst;
      prev_ipc   = inst_pc;
   endtask

   initial begin
      int base;
      logic [31:0] rp;
      rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

      // reset
      lat = 1;
      repeat (3) step(1, 1, 1, 0, 0);
      chk("rst_addr", imem_addr, RPC);

      // first fetch after reset
      step(0, 1, 1, 0, 0);
      chk("first_reqv", imem_req_valid, 1);
      chk("first_addr", imem_addr, RPC);
      step(0, 1, 1, 0, 0);
      chk("wait_iv", inst_valid, 0);
      step(0, 1, 1, 0, 0);
      chk("hold_iv", inst_valid, 1);
      chk("hold_inst", inst, 32'h0010_0093);
      chk("hold_pc", inst_pc, RPC);
      step(0, 1, 1, 0, 0);
      chk("next_reqv", imem_req_valid, 1);
      chk("next_addr", imem_addr, RPC + 32'd4);

      // backpressure in HOLD
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 0);
         chk("bp_iv", inst_valid, 1);
         chk("bp_reqv", imem_req_valid, 0);
         chk("bp_pc", inst_pc, RPC + 32'd4);
      end
      step(0, 1, 1, 0, 0);
      lat = 3;
      step(0, 1, 1, 0, 0);
      chk("bp_next_addr", imem_addr, RPC + 32'd8);

      // redirect during WAIT, stale response two cycles later
      step(0, 1, 1, 1, 32'h8000_0103);
      step(0, 1, 1, 0, 0);
      lat = 1;
      step(0, 1, 1, 0, 0);
      chk("drop_iv", inst_valid, 0);
      step(0, 1, 1, 0, 0);
      chk("drop_reqv", imem_req_valid, 1);
      chk("drop_addr", imem_addr, 32'h8000_0100);

      // redirect + inst_ready in HOLD
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 1, 32'h8000_0200);
      step(0, 0, 1, 0, 0);
      chk("rh_iv0", inst_valid, 0);
      chk("rh_addr", imem_addr, 32'h8000_0200);
      step(0, 1, 1, 0, 0);
      chk("rh_iv1", inst_valid, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("rh_pc", inst_pc, 32'h8000_0200);

      // address wrap
      step(0, 1, 1, 1, 32'hFFFF_FFFC);
      step(0, 1, 1, 0, 0);
      chk("wrap_req", imem_addr, 32'hFFFF_FFFC);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("wrap_hold", inst_pc, 32'hFFFF_FFFC);
      lat = 2;
      step(0, 1, 1, 0, 0);
      chk("wrap_addr", imem_addr, 32'h0000_0000);

      // reset mid-WAIT, response lands after reset release
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("rw_resp", imem_resp_valid, 1);
      chk("rw_reqv", imem_req_valid, 1);
      chk("rw_addr", imem_addr, RPC);
      step(0, 0, 1, 0, 0);
      chk("rw_iv", inst_valid, 0);
      lat = 1;
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("rw_inst", inst, 32'h0010_0093);
      chk("rw_pc", inst_pc, RPC);

      // randomized traffic
      base = delivered;
      for (int i = 0; i < 4000; i++) begin
         lat = $urandom_range(1, 3);
         if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         else                           rp = RPC + $urandom_range(0, 255);
         step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
              $urandom_range(0, 11) == 0, rp);
      end
      chk("live", (delivered - base) > 100, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
